// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: controller handshake, function-under-test drive and result bundle.
interface truth_table_sweeper_if;
  logic        start, abort, s, a, b, c, d, busy, done, pass;
  logic [15:0] expected, table_out;
  logic [4:0]  err_count;
  logic [3:0]  first_err;
  modport master(output start, abort, expected, s,
                 input a, b, c, d, busy, done, table_out, pass, err_count, first_err);
  modport slave(input start, abort, expected, s,
                output a, b, c, d, busy, done, table_out, pass, err_count, first_err);
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 vectors of a 4-input block, captures s and scores it against a golden table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 2
) (
  input logic                  clk,
  input logic                  reset,
  truth_table_sweeper_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d, cnt_q, cnt_d, first_q, first_d;
  logic [15:0] exp_q, exp_d, tab_q, tab_d;
  logic [4:0]  err_q, err_d;
  logic        pass_q, pass_d, mis;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    exp_d   = exp_q;
    tab_d   = tab_q;
    err_d   = err_q;
    pass_d  = pass_q;
    mis     = io.s != exp_q[idx_q];
    if (state_q == IDLE && io.start) begin
      state_d = RUN;
      exp_d   = io.expected;
      tab_d   = '0;
      err_d   = '0;
      first_d = '0;
      pass_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = 4'(SETTLE - 1);
    end else if (state_q == RUN) begin
      if (io.abort) begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        tab_d[idx_q] = io.s;
        err_d        = err_q + 5'(mis);
        first_d      = (mis && err_q == '0) ? idx_q : first_q;
        // idx wraps to 0 after vector 15, so the drive returns to 0 on entering DONE
        idx_d        = idx_q + 4'd1;
        cnt_d        = idx_q == 4'd15 ? 4'd0 : 4'(SETTLE - 1);
        state_d      = idx_q == 4'd15 ? DONE : RUN;
        pass_d       = idx_q == 4'd15 && err_d == '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      exp_q   <= '0;
      tab_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      tab_q   <= tab_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end
  assign {io.a, io.b, io.c, io.d} = idx_q;
  assign io.busy      = state_q == RUN;
  assign io.done      = state_q == DONE;
  assign io.table_out = tab_q;
  assign io.pass      = pass_q;
  assign io.err_count = err_q;
  assign io.first_err = first_q;
endmodule
